// File: rtl/obi_pkg.sv
// Shared OBI request/response types and helpers for the memory responder.
// The LFSR step is kept here so every stall generator in the slice uses the same polynomial.
package obi_pkg;

  localparam int OBI_AW = 32;
  localparam int OBI_DW = 32;
  localparam int OBI_BW = OBI_DW / 8;

  typedef struct packed {
    logic [OBI_AW-1:0] addr;
    logic              we;
    logic [OBI_BW-1:0] be;
    logic [OBI_DW-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [OBI_DW-1:0] rdata;
    logic              err;
  } obi_rsp_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-order response queue; each entry ages from 0 after push, head_ready once head age >= LATENCY-1.
// State-only latency; the caller guarantees no push when full and no pop when empty.
module obi_rsp_fifo
  import obi_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter int  LATENCY = 1,
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int AGW     = $clog2(LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  obi_rsp_t      push_dat,
  input  logic          pop_vld,
  output obi_rsp_t      head_dat,
  output logic          head_ready,
  output logic [CW-1:0] count
);

  obi_rsp_t       store [DEPTH];
  logic [AGW-1:0] age   [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           empty;
  logic           full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign head_dat   = store[rd_ptr];
  assign head_ready = !empty && (age[rd_ptr] >= AGW'(LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      // Ages saturate so a long-waiting head never wraps back below the ready threshold.
      for (int i = 0; i < DEPTH; i++) begin
        if (age[i] != AGW'(LATENCY)) age[i] <= age[i] + AGW'(1);
      end
      if (push_vld) begin
        age[wr_ptr] <= '0;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_vld) rd_ptr <= ptr_inc(rd_ptr);
      if (push_vld && !pop_vld)      count <= count + CW'(1);
      else if (!push_vld && pop_vld) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) store[wr_ptr] <= push_dat;
  end

  assert property (@(posedge clk) disable iff (rst) !(pop_vld && empty))
    else $error("obi_rsp_fifo: pop while empty");
  assert property (@(posedge clk) disable iff (rst) !(push_vld && full))
    else $error("obi_rsp_fifo: push while full");

endmodule

// File: rtl/obi_mem_responder.sv
// OBI v1 memory responder: byte-enabled word RAM, in-order responses RSP_LATENCY cycles after accept.
// Grant drops while MAX_OUTSTANDING responses are pending or when the optional LFSR stall bit is set.
module obi_mem_responder
  import obi_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          RSP_LATENCY     = 1,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [OBI_AW-1:0] addr_i,
  input  logic              we_i,
  input  logic [OBI_BW-1:0] be_i,
  input  logic [OBI_DW-1:0] wdata_i,
  output logic              rvalid_o,
  output logic [OBI_DW-1:0] rdata_o,
  output logic              err_o
);

  localparam int                IW         = $clog2(MEM_WORDS);
  localparam int                CW         = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OBI_AW-1:0] BYTE_LIMIT = OBI_AW'(MEM_WORDS) << 2;

  obi_req_t          req;
  obi_rsp_t          acc_rsp;
  obi_rsp_t          head_rsp;
  logic [IW-1:0]     idx;
  logic              dec_err;
  logic              accept;
  logic              stall;
  logic              head_ready;
  logic [CW-1:0]     count;
  logic [15:0]       lfsr;
  logic [OBI_DW-1:0] ram [MEM_WORDS];

  assign req = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  // No full bypass: a pop in the same cycle does not free a slot for this request.
  assign stall  = STALL_EN && lfsr[0];
  assign gnt_o  = !rst_i && req_i && (count < CW'(MAX_OUTSTANDING)) && !stall;
  assign accept = req_i && gnt_o;

  assign idx     = req.addr[2 +: IW];
  assign dec_err = (req.addr[1:0] != 2'b00) || (req.addr >= BYTE_LIMIT);

  always_comb begin
    acc_rsp.err   = dec_err;
    acc_rsp.rdata = (dec_err || req.we) ? '0 : ram[idx];
  end

  always_ff @(posedge clk_i) begin
    if (accept && req.we && !dec_err) begin
      for (int b = 0; b < OBI_BW; b++) begin
        if (req.be[b]) ram[idx][8*b +: 8] <= req.wdata[8*b +: 8];
      end
    end
  end

  obi_rsp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .LATENCY (RSP_LATENCY)
  ) u_rsp_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push_vld   (accept),
    .push_dat   (acc_rsp),
    .pop_vld    (head_ready),
    .head_dat   (head_rsp),
    .head_ready (head_ready),
    .count      (count)
  );

  // Outputs come straight from the queue flops, so accept in cycle N shows rvalid in N+RSP_LATENCY.
  assign rvalid_o = head_ready;
  assign rdata_o  = head_ready ? head_rsp.rdata : '0;
  assign err_o    = head_ready && head_rsp.err;

  assert property (@(posedge clk_i) disable iff (rst_i)
                   (req_i && !gnt_o) |=> (req_i && $stable(req)))
    else $error("obi_mem_responder: initiator changed request before grant");

endmodule

// File: tb/tb_obi_mem_responder.sv
// Three responder configurations checked cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_obi_mem_responder;

  localparam int          NI   = 3;
  localparam int          MW   = 256;
  localparam logic [15:0] SEED = 16'hACE1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 2;
  endfunction
  function automatic int mo_of(input int k);
    return (k == 2) ? 3 : 2;
  endfunction
  function automatic bit stl_of(input int k);
    return (k == 2);
  endfunction

  logic        clk;
  logic        rst;
  logic        req    [NI];
  logic        gnt    [NI];
  logic [31:0] addr   [NI];
  logic        we     [NI];
  logic [3:0]  be     [NI];
  logic [31:0] wdata  [NI];
  logic        rvalid [NI];
  logic [31:0] rdata  [NI];
  logic        err    [NI];

  obi_mem_responder #(.MEM_WORDS(MW), .MAX_OUTSTANDING(2), .RSP_LATENCY(1), .STALL_EN(1'b0),
                      .LFSR_SEED(SEED)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  obi_mem_responder #(.MEM_WORDS(MW), .MAX_OUTSTANDING(2), .RSP_LATENCY(4), .STALL_EN(1'b0),
                      .LFSR_SEED(SEED)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  obi_mem_responder #(.MEM_WORDS(MW), .MAX_OUTSTANDING(3), .RSP_LATENCY(2), .STALL_EN(1'b1),
                      .LFSR_SEED(SEED)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stall sequence from the polynomial: taps at exponents 16,14,13,11 -> mask bits 15,13,12,10.
  localparam logic [15:0] TAPMASK = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);
  logic [15:0] lm;
  always @(posedge clk or posedge rst) begin
    if (rst) lm <= SEED;
    else     lm <= (lm >> 1) ^ (lm[0] ? TAPMASK : 16'h0);
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        eq[$];
  logic [31:0] mm [NI][MW];
  int          cyc;
  int          n_assert;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock of instance k: predict and compare at negedge, update the model, return at posedge+1.
  task automatic tick(input int k, output bit acc);
    bit   eg;
    bit   erv;
    exp_t e;
    int   w;
    @(negedge clk);
    eg  = req[k] && (eq.size() < mo_of(k)) && !(stl_of(k) && lm[0]);
    erv = (eq.size() > 0) && (cyc >= eq[0].due);
    chk($sformatf("gnt%0d c%0d", k, cyc), 32'(gnt[k]), 32'(eg));
    chk($sformatf("rvalid%0d c%0d", k, cyc), 32'(rvalid[k]), 32'(erv));
    chk($sformatf("rdata%0d c%0d", k, cyc), rdata[k], erv ? eq[0].rdata : 32'h0);
    chk($sformatf("err%0d c%0d", k, cyc), 32'(err[k]), erv ? 32'(eq[0].err) : 32'h0);
    if (erv) void'(eq.pop_front());
    if (eg) begin
      w       = int'(addr[k] >> 2);
      e.err   = (addr[k][1:0] != 2'b00) || (addr[k] >= 32'(MW * 4));
      e.rdata = 32'h0;
      e.due   = cyc + lat_of(k);
      if (!e.err && we[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[k][b]) mm[k][w][8*b +: 8] = wdata[k][8*b +: 8];
        end
      end else if (!e.err) begin
        e.rdata = mm[k][w];
      end
      eq.push_back(e);
    end
    acc = eg;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input int k, input bit wr, input logic [31:0] a, input logic [3:0] bm,
                       input logic [31:0] d);
    bit got = 1'b0;
    req[k] = 1'b1; we[k] = wr; addr[k] = a; be[k] = bm; wdata[k] = d;
    for (int n = 0; n < 40 && !got; n++) tick(k, got);
    chk($sformatf("issue%0d granted @%h", k, a), 32'(got), 32'h1);
  endtask

  task automatic drain(input int k);
    bit a;
    int n = 0;
    req[k] = 1'b0;
    while (eq.size() > 0 && n < 30) begin
      tick(k, a);
      n++;
    end
    chk($sformatf("drain%0d", k), 32'(eq.size()), 32'h0);
  endtask

  task automatic rand_req(input int k);
    int w = int'($urandom_range(15));
    case ($urandom_range(9))
      0:       addr[k] = 32'(w * 4 + int'($urandom_range(3, 1)));
      1:       addr[k] = 32'(MW * 4 + int'($urandom_range(4095)));
      default: addr[k] = 32'(w * 4);
    endcase
    we[k]    = 1'($urandom_range(1));
    be[k]    = 4'($urandom);
    wdata[k] = $urandom;
    req[k]   = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int n_acc;
    int budget;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
    end
    rst = 1'b1;

    // Reset state, with a request pending on instance 0.
    req[0] = 1'b1;
    #2;
    chk("reset gnt", 32'(gnt[0]), 32'h0);
    chk("reset rvalid", 32'(rvalid[0]), 32'h0);
    chk("reset rdata", rdata[0], 32'h0);
    chk("reset err", 32'(err[0]), 32'h0);
    req[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write then read back-to-back, single-cycle latency.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
    drain(0);

    // Partial byte enables merge into the existing word.
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0);
    drain(0);

    // Misaligned, out-of-range and erroring write leave RAM untouched.
    issue(0, 1'b0, 32'h21, 4'h0, 32'h0);
    issue(0, 1'b0, 32'(MW * 4), 4'h0, 32'h0);
    issue(0, 1'b1, 32'h22, 4'hF, 32'hCAFEF00D);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0);
    issue(0, 1'b1, 32'h24, 4'h0, 32'h55555555);
    drain(0);

    // Outstanding limit with long latency and request held high.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; be[1] = 4'hF; wdata[1] = 32'h00000005;
    for (int i = 0; i < 6; i++) tick(1, a);
    drain(1);

    // Random traffic under LFSR stalls; prefill the words the traffic touches.
    for (int w = 0; w < 16; w++) issue(2, 1'b1, 32'(w * 4), 4'hF, $urandom);
    n_acc  = 0;
    budget = 0;
    req[2] = 1'b0;
    while (n_acc < 200 && budget < 6000) begin
      if (!req[2] && $urandom_range(3) != 0) rand_req(2);
      tick(2, a);
      budget++;
      if (a) begin
        n_acc++;
        if ($urandom_range(3) != 0) rand_req(2);
        else req[2] = 1'b0;
      end
    end
    chk("random accepted", 32'(n_acc), 32'd200);
    drain(2);

    // Reset with two responses pending, at the cycle the first one is due.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h48; be[1] = 4'hF; wdata[1] = 32'h12345678;
    tick(1, a);
    tick(1, a);
    req[1] = 1'b0;
    tick(1, a);
    tick(1, a);
    rst    = 1'b1;
    req[1] = 1'b1;
    #1;
    chk("rst rvalid", 32'(rvalid[1]), 32'h0);
    chk("rst rdata", rdata[1], 32'h0);
    chk("rst gnt", 32'(gnt[1]), 32'h0);
    req[1] = 1'b0;
    eq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h4C; be[1] = 4'hF; wdata[1] = 32'h0BADC0DE;
    tick(1, a);
    req[1] = 1'b0;
    for (int i = 0; i < 8; i++) tick(1, a);
    chk("post-reset drained", 32'(eq.size()), 32'h0);

    // Stall pattern after reset must restart from the seed.
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h8; be[2] = 4'h0; wdata[2] = 32'h0;
    for (int i = 0; i < 20; i++) tick(2, a);
    drain(2);
    issue(2, 1'b0, 32'h8, 4'h0, 32'h0);
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
